spi_shift_register: RTL and testbench
=====================================

Name: spi_shift_register

Overview:
- Datapath register for the SPI memory slave, sitting directly under the slave controller FSM.
- Shifts MOSI bits in on conditioned SCLK rising-edge strobes.
- Parallel-loads a memory read word when the FSM asserts its shift-register write enable, and presents the MSB on a registered MISO output updated on SCLK falling-edge strobes.
- Exposes the word in parallel to the address latch and data memory, and pulses byte_done after every WIDTH-th shifted bit.

Parameters:
- WIDTH, 8, shift register / SPI word width in bits (min 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- sclk_posedge  input  1  one-clk strobe: conditioned SCLK rising edge
- sclk_negedge  input  1  one-clk strobe: conditioned SCLK falling edge
- chipselect  input  1  conditioned chip select; 1 = deselected, 0 = active transaction
- mosi  input  1  conditioned serial data in
- parallel_load  input  1  load parallel_in (driven by FSM shift-reg write enable)
- parallel_in  input  WIDTH  word read from data memory
- miso_enable  input  1  FSM request to drive MISO
- parallel_out  output  WIDTH  current shift register contents (to address latch / data memory)
- miso  output  1  registered serial data out
- miso_oe  output  1  output enable for the top-level MISO tri-state pad
- byte_done  output  1  one-clk pulse after WIDTH bits have been shifted in

Behaviour:
- Reset: shift_reg=0, parallel_out=0, miso=0, miso_oe=0, bit_count=0, byte_done=0.
- Per-cycle priority: reset > chipselect=1 > parallel_load > sclk_posedge > sclk_negedge.
- chipselect=1 (deselected):
  - bit_count<=0, miso_oe<=0, byte_done<=0.
  - shift_reg and miso hold their values.
  - All strobes and parallel_load are ignored.
- parallel_load=1 (chipselect=0):
  - shift_reg<=parallel_in, miso<=parallel_in[WIDTH-1], bit_count<=0.
  - Any coincident sclk_posedge/sclk_negedge in the same cycle is discarded.
- sclk_posedge (chipselect=0, no load):
  - shift_reg<={shift_reg[WIDTH-2:0], mosi}.
  - bit_count<=bit_count+1; when bit_count==WIDTH-1 it wraps to 0 and byte_done<=1 for exactly one cycle.
- sclk_negedge (chipselect=0, no load, no posedge): miso<=shift_reg[WIDTH-1].
- sclk_posedge and sclk_negedge together: illegal from the conditioner; posedge processing wins, negedge is ignored, no error flag.
- Latency:
  - parallel_out equals shift_reg; new contents are visible the cycle after the strobe or load.
  - byte_done asserts the cycle after the WIDTH-th posedge strobe.
- byte_done is 0 in every cycle other than that single pulse.
- miso_oe is registered every cycle as (miso_enable & ~chipselect), i.e. one-cycle lag from miso_enable.
- MISO timing (SPI mode 0):
  - After a load, the first bit is on miso before the master's next rising edge.
  - Each subsequent falling strobe presents the next bit, MSB first.
- Reset mid-transaction: all state clears in the same cycle; no partial byte_done.
- Chipselect rising mid-byte: bit_count clears; a following transaction starts counting from 0.
- bit_count width is clog2(WIDTH); no overflow is possible.

Decomposition:
- Shared package spi_pkg:
  - SPI_WORD_WIDTH=8.
  - SPI_ADDR_WIDTH=7.
  - SPI_RW_BIT=0 (LSB of the first byte is the read/write flag).
  - Constant for the mode-0 convention.
- Implementation is a single flat module; no sub-module is warranted. The bit counter is inline.

Test Plan:
- Reset with chipselect=0 and mosi=1 toggling strobes -> parallel_out=0x00, miso=0, miso_oe=0, byte_done=0 throughout reset.
- chipselect=0; shift bits 1,0,1,1,0,1,0,0 on 8 posedge strobes -> parallel_out=0xB4; byte_done high for exactly 1 clk after the 8th strobe; bit_count back to 0.
- parallel_load with parallel_in=0xA5, then 8 negedge strobes with miso_enable=1 -> miso sequence 1 (at load),0,1,0,0,1,0,1; miso_oe=1 one clk after miso_enable rises.
- parallel_load=1 and sclk_posedge=1 in the same cycle with parallel_in=0x3C, mosi=1 -> parallel_out=0x3C; bit_count=0; no shift.
- 3 posedge strobes, then chipselect=1, then chipselect=0 and 8 more strobes -> byte_done only after the 8 new strobes; miso_oe=0 while deselected.
- reset asserted after 5 posedge strobes -> next cycle parallel_out=0, bit_count=0; byte_done never pulses.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI memory slave
package spi_pkg;

   // Width of one SPI word; the shift register defaults to this.
   localparam int SPI_WORD_WIDTH = 8;

   // Address field width carried in the first byte.
   localparam int SPI_ADDR_WIDTH = 7;

   // Bit position of the read/write flag within the first byte.
   localparam int SPI_RW_BIT = 0;

   // Mode 0: SCLK idles low, data sampled on rising edge, changed on falling edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_shift_register.sv
// rtl/spi_shift_register.sv - SPI slave datapath shift register with MISO output
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   sclk_posedge     one-clk strobe: conditioned SCLK rising edge (shift in)
//   sclk_negedge     one-clk strobe: conditioned SCLK falling edge (update miso)
//   chipselect       1 = deselected, 0 = active transaction
//   mosi             serial data in
//   parallel_load    load parallel_in into the shift register
//   parallel_in      word from data memory
//   miso_enable      request to drive the MISO pad
//   parallel_out     current shift register contents
//   miso             registered serial data out
//   miso_oe          MISO pad output enable
//   byte_done        one-clk pulse after every WIDTH-th shifted bit
module spi_shift_register
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WORD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk_posedge,
   input  logic             sclk_negedge,
   input  logic             chipselect,
   input  logic             mosi,
   input  logic             parallel_load,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             miso_enable,
   output logic [WIDTH-1:0] parallel_out,
   output logic             miso,
   output logic             miso_oe,
   output logic             byte_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
   logic             miso_q, miso_d;
   logic             miso_oe_q, miso_oe_d;
   logic [CW-1:0]    bit_count_q, bit_count_d;
   logic             byte_done_q, byte_done_d;

   always_comb begin
      shift_reg_d = shift_reg_q;
      miso_d      = miso_q;
      bit_count_d = bit_count_q;
      byte_done_d = 1'b0;
      miso_oe_d   = miso_enable & ~chipselect;

      if (chipselect) begin
         // Deselected: abandon any partial word, keep data and miso.
         bit_count_d = '0;
      end else if (parallel_load) begin
         // Present the MSB immediately so it is valid before the first rising SCLK.
         shift_reg_d = parallel_in;
         miso_d      = parallel_in[WIDTH-1];
         bit_count_d = '0;
      end else if (sclk_posedge) begin
         // A coincident falling strobe is illegal and simply dropped here.
         shift_reg_d = {shift_reg_q[WIDTH-2:0], mosi};
         if (bit_count_q == LAST_BIT) begin
            bit_count_d = '0;
            byte_done_d = 1'b1;
         end else begin
            bit_count_d = bit_count_q + 1'b1;
         end
      end else if (sclk_negedge) begin
         miso_d = shift_reg_q[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg_q <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         bit_count_q <= '0;
         byte_done_q <= 1'b0;
      end else begin
         shift_reg_q <= shift_reg_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         bit_count_q <= bit_count_d;
         byte_done_q <= byte_done_d;
      end
   end

   assign parallel_out = shift_reg_q;
   assign miso         = miso_q;
   assign miso_oe      = miso_oe_q;
   assign byte_done    = byte_done_q;

endmodule

// File: tb/tb_spi_shift_register.sv
// tb/tb_spi_shift_register.sv - randomized self-checking bench for spi_shift_register
module tb_spi_shift_register;

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk_posedge;
   logic       sclk_negedge;
   logic       chipselect;
   logic       mosi;
   logic       parallel_load;
   logic [7:0] parallel_in;
   logic       miso_enable;
   logic [7:0] parallel_out;
   logic       miso;
   logic       miso_oe;
   logic       byte_done;

   int checks   = 0;
   int failures = 0;
   int done_seen = 0;

   // Reference model: the received word, bits received so far, miso/oe and pulse.
   int m_word = 0;
   int m_bits = 0;
   int m_miso = 0;
   int m_oe   = 0;
   int m_done = 0;

   spi_shift_register #(.WIDTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .sclk_posedge  (sclk_posedge),
      .sclk_negedge  (sclk_negedge),
      .chipselect    (chipselect),
      .mosi          (mosi),
      .parallel_load (parallel_load),
      .parallel_in   (parallel_in),
      .miso_enable   (miso_enable),
      .parallel_out  (parallel_out),
      .miso          (miso),
      .miso_oe       (miso_oe),
      .byte_done     (byte_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one clock of inputs, advance the model, and compare all outputs.
   task automatic cycle(input logic rst, input logic cs, input logic ps,
                        input logic ns, input logic mo, input logic pl,
                        input logic [7:0] pin, input logic me);
      reset = rst; chipselect = cs; sclk_posedge = ps; sclk_negedge = ns;
      mosi = mo; parallel_load = pl; parallel_in = pin; miso_enable = me;
      @(posedge clk);
      #1;
      if (rst) begin
         m_word = 0; m_bits = 0; m_miso = 0; m_oe = 0; m_done = 0;
      end else begin
         m_oe   = (me && !cs) ? 1 : 0;
         m_done = 0;
         if (cs) begin
            m_bits = 0;
         end else if (pl) begin
            m_word = int'(pin);
            m_miso = (m_word / 128) % 2;
            m_bits = 0;
         end else if (ps) begin
            m_word = (m_word * 2 + int'(mo)) % 256;
            m_bits = m_bits + 1;
            if (m_bits == 8) begin
               m_bits = 0;
               m_done = 1;
            end
         end else if (ns) begin
            m_miso = (m_word / 128) % 2;
         end
      end
      if (byte_done) done_seen++;
      check("parallel_out", int'(parallel_out), m_word);
      check("miso", int'(miso), m_miso);
      check("miso_oe", int'(miso_oe), m_oe);
      check("byte_done", int'(byte_done), m_done);
   endtask

   task automatic idle(input logic me);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, me);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] a5;
      pat = 8'hB4;
      a5  = 8'hA5;

      // Reset with strobes toggling and mosi=1.
      for (int i = 0; i < 6; i++)
         cycle(1'b1, 1'b0, i[0], ~i[0], 1'b1, 1'b0, 8'hFF, 1'b1);
      check("reset_out", int'(parallel_out), 0);
      check("reset_oe", int'(miso_oe), 0);

      // Shift 0xB4 MSB first on 8 rising strobes.
      done_seen = 0;
      for (int i = 7; i >= 0; i--) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, pat[i], 1'b0, 8'h00, 1'b0);
         if (i == 0) check("done_after_8th", int'(byte_done), 1);
      end
      idle(1'b0);
      check("shift_b4", int'(parallel_out), 8'hB4);
      check("done_pulses", done_seen, 1);

      // Load 0xA5 and walk it out MSB first.
      idle(1'b1);
      check("oe_lag", int'(miso_oe), 1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
      check("miso_at_load", int'(miso), 1);
      for (int i = 6; i >= 0; i--) begin
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
         check("miso_seq", int'(miso), int'(a5[i]));
      end

      // Load and rising strobe together: load wins, counter restarts.
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
      check("load_wins", int'(parallel_out), 8'h3C);
      done_seen = 0;
      for (int i = 0; i < 7; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("no_done_7", done_seen, 0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("done_at_8", done_seen, 1);

      // Deselect mid-byte restarts the count.
      done_seen = 0;
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      check("oe_deselected", int'(miso_oe), 0);
      for (int i = 0; i < 7; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("cs_no_early_done", done_seen, 0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("cs_done_after_8", done_seen, 1);

      // Reset after 5 strobes.
      done_seen = 0;
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("reset_mid_out", int'(parallel_out), 0);
      for (int i = 0; i < 7; i++)
         cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("reset_no_partial", done_seen, 0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      check("reset_full_byte", done_seen, 1);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         logic rst, cs, ps, ns, pl, me, mo;
         int   sel;
         rst = ($urandom_range(0, 99) == 0);
         cs  = ($urandom_range(0, 29) == 0);
         pl  = ($urandom_range(0, 19) == 0);
         sel = $urandom_range(0, 15);
         ps  = (sel < 6) || (sel == 15);
         ns  = (sel >= 6 && sel < 12) || (sel == 15);
         me  = ($urandom_range(0, 3) != 0);
         mo  = 1'($urandom);
         cycle(rst, cs, ps, ns, mo, pl, 8'($urandom), me);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
